// File: rtl/kf8255_pkg.sv
// Shared constants and types for the KF8255 PPI group-control logic.
package kf8255_pkg;

  // Port direction encoding used in the per-port I/O register.
  localparam logic PORT_INPUT  = 1'b1;
  localparam logic PORT_OUTPUT = 1'b0;

  // Mode-select encodings understood by the group datapaths.
  localparam logic [1:0] KF8255_CONTROL_MODE_0 = 2'd0;
  localparam logic [1:0] KF8255_CONTROL_MODE_1 = 2'd1;
  localparam logic [1:0] KF8255_CONTROL_MODE_2 = 2'd2;

  // Group sequencing states: idle/ready, one-cycle port clear, settle wait.
  typedef enum logic [1:0] {
    GRP_READY  = 2'd0,
    GRP_CLEAR  = 2'd1,
    GRP_SETTLE = 2'd2
  } kf8255_group_state_t;

endpackage

// File: rtl/kf8255_group_ctrl.sv
// Group-control register block: latches mode and per-port direction from the
// internal bus, rejects illegal modes, and runs a clear/settle sequence after
// every accepted configuration change before reporting ready again.
// All state lives on the falling clock edge; every output is a flop.
//
// Handshake: a write is a single-cycle strobe. internal_data_bus is sampled
// whenever write_register is 1 at a falling edge; there is no back-pressure,
// and group_ready only reports that port logic has re-initialised -- writes
// are accepted in every state (a changed legal write restarts the sequence).
module kf8255_group_ctrl
  import kf8255_pkg::*;
#(
  parameter int PORT_COUNT    = 2,
  parameter int MODE_WIDTH    = 2,
  parameter int MAX_MODE      = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [MODE_WIDTH+PORT_COUNT-1:0] internal_data_bus,
  input  logic                            write_register,
  output logic                            update_group_mode,
  output logic [MODE_WIDTH-1:0]           mode_select_reg,
  output logic [PORT_COUNT-1:0]           port_io_reg,
  output logic                            clear_outputs,
  output logic                            group_ready,
  output logic                            mode_error,
  output kf8255_group_state_t             group_state
);

  // Settle counter only has to reach SETTLE_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  // One extra bit so a MAX_MODE equal to the field maximum still compares.
  localparam logic [MODE_WIDTH:0] MAX_MODE_EXT = (MODE_WIDTH + 1)'(MAX_MODE);
  localparam logic [MODE_WIDTH-1:0] RESET_MODE = MODE_WIDTH'(KF8255_CONTROL_MODE_0);

  logic [MODE_WIDTH-1:0] bus_mode;
  logic [PORT_COUNT-1:0] bus_io;
  logic                  bus_illegal;
  logic                  bus_changed;
  logic [CNT_W-1:0]      settle_cnt;

  // Split the bus into fields and classify the write against current config.
  always_comb begin
    bus_mode    = internal_data_bus[MODE_WIDTH+PORT_COUNT-1:PORT_COUNT];
    bus_io      = internal_data_bus[PORT_COUNT-1:0];
    bus_illegal = ({1'b0, bus_mode} > MAX_MODE_EXT);
    bus_changed = (bus_mode != mode_select_reg) || (bus_io != port_io_reg);
  end

  // Config registers, error flag and clear/settle sequencer with registered outputs.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      mode_select_reg   <= RESET_MODE;
      port_io_reg       <= {PORT_COUNT{PORT_INPUT}};
      update_group_mode <= 1'b0;
      clear_outputs     <= 1'b0;
      group_ready       <= 1'b1;
      mode_error        <= 1'b0;
      group_state       <= GRP_READY;
      settle_cnt        <= '0;
    end else begin
      update_group_mode <= 1'b0;

      // The error flag reflects only the most recent write.
      if (write_register) begin
        mode_error <= bus_illegal;
      end

      if (write_register && !bus_illegal && bus_changed) begin
        // Latest changed write wins, even mid-sequence.
        mode_select_reg   <= bus_mode;
        port_io_reg       <= bus_io;
        update_group_mode <= 1'b1;
        clear_outputs     <= 1'b1;
        group_ready       <= 1'b0;
        group_state       <= GRP_CLEAR;
        settle_cnt        <= '0;
      end else begin
        case (group_state)
          GRP_READY: begin
            clear_outputs <= 1'b0;
            group_ready   <= 1'b1;
          end
          GRP_CLEAR: begin
            clear_outputs <= 1'b0;
            settle_cnt    <= '0;
            if (SETTLE_CYCLES == 0) begin
              group_state <= GRP_READY;
              group_ready <= 1'b1;
            end else begin
              group_state <= GRP_SETTLE;
            end
          end
          GRP_SETTLE: begin
            if (settle_cnt == CNT_LAST) begin
              group_state <= GRP_READY;
              group_ready <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          default: begin
            group_state   <= GRP_READY;
            group_ready   <= 1'b1;
            clear_outputs <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
